// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS control unit.
// It steps each instruction through IF, ID and then the EXE, MEM and WB states
// that the instruction needs. It drives every datapath enable and select.
//
// Ports:
//   CLK, RST   : clock (state changes on posedge); asynchronous active-high reset
//   opcode     : instr[31:26] from the instruction register
//   zero       : ALU zero flag, used by beq
//   state      : current state, for debug and display
//   PCWre      : PC load enable
//   IRWre      : instruction register load enable
//   RegWre     : register-file write enable
//   RegDst     : write address select (00=$31, 01=rt, 10=rd)
//   WrRegDSrc  : write data select (0=PC+4, 1=DB bus)
//   ALUSrcB    : ALU B operand (0=rt data, 1=extended immediate)
//   ExtSel     : immediate extension (0=zero-extend, 1=sign-extend)
//   ALUOp      : ALU operation (000 add, 001 sub, 010 and, 011 or)
//   mRD, mWR   : data-memory read and write strobes
//   DBDataSrc  : DB bus source (0=ALU result, 1=memory data)
//   PCSrc      : next PC (00 PC+4, 01 branch, 10 rs, 11 jump target)
//
// All outputs are combinational from the state and the opcode. As a result,
// the register file's negedge write lands in the middle of the writeback cycle.
module multicycle_control_fsm #(
  parameter int              OP_W    = 6,
  parameter logic [OP_W-1:0] HALT_OP = 6'b111111
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [OP_W-1:0] opcode,
  input  logic            zero,
  output logic [2:0]      state,
  output logic            PCWre,
  output logic            IRWre,
  output logic            RegWre,
  output logic [1:0]      RegDst,
  output logic            WrRegDSrc,
  output logic            ALUSrcB,
  output logic            ExtSel,
  output logic [2:0]      ALUOp,
  output logic            mRD,
  output logic            mWR,
  output logic            DBDataSrc,
  output logic [1:0]      PCSrc
);

  localparam logic [OP_W-1:0] OP_ADD  = 6'b000000;
  localparam logic [OP_W-1:0] OP_SUB  = 6'b000001;
  localparam logic [OP_W-1:0] OP_OR   = 6'b010000;
  localparam logic [OP_W-1:0] OP_AND  = 6'b010001;
  localparam logic [OP_W-1:0] OP_ADDI = 6'b000010;
  localparam logic [OP_W-1:0] OP_ORI  = 6'b010010;
  localparam logic [OP_W-1:0] OP_SW   = 6'b110000;
  localparam logic [OP_W-1:0] OP_LW   = 6'b110001;
  localparam logic [OP_W-1:0] OP_BEQ  = 6'b110100;
  localparam logic [OP_W-1:0] OP_J    = 6'b111000;
  localparam logic [OP_W-1:0] OP_JR   = 6'b111001;
  localparam logic [OP_W-1:0] OP_JAL  = 6'b111010;

  typedef enum logic [2:0] {
    S_IF     = 3'b000,
    S_ID     = 3'b001,
    S_EXE_LS = 3'b010,
    S_MEM    = 3'b011,
    S_WB_LD  = 3'b100,
    S_EXE_BR = 3'b101,
    S_EXE_AL = 3'b110,
    S_WB_AL  = 3'b111
  } state_t;

  state_t stateReg, nextState;

  logic isRType, isImm, isLw, isSw, isBeq, isJ, isJr, isJal, isHalt;

  assign isRType = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                   (opcode == OP_OR)  || (opcode == OP_AND);
  assign isImm   = (opcode == OP_ADDI) || (opcode == OP_ORI);
  assign isLw    = (opcode == OP_LW);
  assign isSw    = (opcode == OP_SW);
  assign isBeq   = (opcode == OP_BEQ);
  assign isJ     = (opcode == OP_J);
  assign isJr    = (opcode == OP_JR);
  assign isJal   = (opcode == OP_JAL);
  assign isHalt  = (opcode == HALT_OP);

  assign state = stateReg;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) stateReg <= S_IF;
    else     stateReg <= nextState;
  end

  always_comb begin
    nextState = stateReg;
    PCWre     = 1'b0;
    IRWre     = 1'b0;
    RegWre    = 1'b0;
    RegDst    = 2'b00;
    WrRegDSrc = 1'b0;
    mRD       = 1'b0;
    mWR       = 1'b0;
    DBDataSrc = 1'b0;
    PCSrc     = 2'b00;

    // The opcode is stable from the end of IF onward, so the ALU-facing
    // selects are decoded from the opcode alone. This holds them constant
    // across every EXE, MEM and WB cycle of the instruction.
    ALUSrcB = isImm || isLw || isSw;
    ExtSel  = (opcode != OP_ORI);
    if (opcode == OP_SUB || isBeq)                 ALUOp = 3'b001;
    else if (opcode == OP_AND)                     ALUOp = 3'b010;
    else if (opcode == OP_OR || opcode == OP_ORI)  ALUOp = 3'b011;
    else                                           ALUOp = 3'b000;

    case (stateReg)
      S_IF: begin
        IRWre     = 1'b1;
        nextState = S_ID;
      end
      S_ID: begin
        if (isHalt)                nextState = S_ID;
        else if (isRType || isImm) nextState = S_EXE_AL;
        else if (isLw || isSw)     nextState = S_EXE_LS;
        else if (isBeq)            nextState = S_EXE_BR;
        else begin
          // j, jr, jal and any unknown opcode (a NOP) all finish in ID.
          nextState = S_IF;
          PCWre     = 1'b1;
          if (isJ || isJal) PCSrc = 2'b11;
          else if (isJr)    PCSrc = 2'b10;
          // jal writes PC+4 into $31. RegDst and WrRegDSrc stay at 00 and 0.
          RegWre = isJal;
        end
      end
      S_EXE_AL: nextState = S_WB_AL;
      S_WB_AL: begin
        RegWre    = 1'b1;
        RegDst    = isRType ? 2'b10 : 2'b01;
        WrRegDSrc = 1'b1;
        PCWre     = 1'b1;
        nextState = S_IF;
      end
      S_EXE_LS: nextState = S_MEM;
      S_MEM: begin
        if (isLw) begin
          mRD       = 1'b1;
          DBDataSrc = 1'b1;
          nextState = S_WB_LD;
        end else begin
          mWR       = isSw;
          PCWre     = 1'b1;
          nextState = S_IF;
        end
      end
      S_WB_LD: begin
        RegWre    = 1'b1;
        RegDst    = 2'b01;
        WrRegDSrc = 1'b1;
        DBDataSrc = 1'b1;
        PCWre     = 1'b1;
        nextState = S_IF;
      end
      S_EXE_BR: begin
        PCSrc     = zero ? 2'b01 : 2'b00;
        PCWre     = 1'b1;
        nextState = S_IF;
      end
      default: nextState = S_IF;
    endcase

    // While reset is held, no enable may disturb the datapath.
    if (RST) begin
      PCWre  = 1'b0;
      IRWre  = 1'b0;
      RegWre = 1'b0;
      mRD    = 1'b0;
      mWR    = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
module tb_multicycle_control_fsm;

  localparam logic [2:0] ST_IF = 3'd0, ST_ID = 3'd1, ST_LS = 3'd2, ST_MEM = 3'd3,
                         ST_WBLD = 3'd4, ST_BR = 3'd5, ST_AL = 3'd6, ST_WBAL = 3'd7;

  localparam logic [5:0] ADD = 6'b000000, SUB = 6'b000001, OR_ = 6'b010000,
                         AND_ = 6'b010001, ADDI = 6'b000010, ORI = 6'b010010,
                         SW = 6'b110000, LW = 6'b110001, BEQ = 6'b110100,
                         J = 6'b111000, JR = 6'b111001, JAL = 6'b111010,
                         HALT = 6'b111111, NOP = 6'b101010;

  typedef struct packed {
    logic [2:0] st;
    logic       pcwre;
    logic       irwre;
    logic       regwre;
    logic [1:0] regdst;
    logic       wrsrc;
    logic       alusrcb;
    logic       extsel;
    logic [2:0] aluop;
    logic       mrd;
    logic       mwr;
    logic       dbsrc;
    logic [1:0] pcsrc;
  } obs_t;

  // clock / reset
  logic CLK = 1'b0;
  logic RST;
  logic [5:0] opcode;
  logic zero;
  always #5 CLK = ~CLK;

  logic [2:0] state;
  logic       PCWre, IRWre, RegWre, WrRegDSrc, ALUSrcB, ExtSel, mRD, mWR, DBDataSrc;
  logic [1:0] RegDst, PCSrc;
  logic [2:0] ALUOp;

  multicycle_control_fsm dut (
    .CLK(CLK), .RST(RST), .opcode(opcode), .zero(zero), .state(state),
    .PCWre(PCWre), .IRWre(IRWre), .RegWre(RegWre), .RegDst(RegDst),
    .WrRegDSrc(WrRegDSrc), .ALUSrcB(ALUSrcB), .ExtSel(ExtSel), .ALUOp(ALUOp),
    .mRD(mRD), .mWR(mWR), .DBDataSrc(DBDataSrc), .PCSrc(PCSrc)
  );

  int n_pass = 0;
  int n_total = 0;

  // Behavioural model: each instruction is a walk of lat(op) steps along its
  // path. Outputs follow from the step, the opcode and the zero flag.
  function automatic logic is_r(input logic [5:0] op);
    return op == ADD || op == SUB || op == OR_ || op == AND_;
  endfunction

  function automatic logic is_i(input logic [5:0] op);
    return op == ADDI || op == ORI;
  endfunction

  function automatic int lat(input logic [5:0] op);
    if (is_r(op) || is_i(op)) return 4;
    if (op == LW)  return 5;
    if (op == SW)  return 4;
    if (op == BEQ) return 3;
    return 2;
  endfunction

  function automatic logic [2:0] path(input logic [5:0] op, input int pos);
    case (pos)
      0: return ST_IF;
      1: return ST_ID;
      2: return (op == LW || op == SW) ? ST_LS : (op == BEQ) ? ST_BR : ST_AL;
      3: return (op == LW || op == SW) ? ST_MEM : ST_WBAL;
      default: return ST_WBLD;
    endcase
  endfunction

  logic [5:0] m_op = NOP;
  int         m_pos = 0;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_pos = 0;
    end else if (m_pos == 0) begin
      m_op  = opcode;
      m_pos = 1;
    end else if (m_pos == lat(m_op) - 1) begin
      if (m_op != HALT) m_pos = 0;
    end else begin
      m_pos = m_pos + 1;
    end
  end

  function automatic obs_t expect_out(input logic [5:0] op, input logic [5:0] pop,
                                      input int pos, input logic z, input logic rst);
    obs_t e;
    logic fin;
    e = '0;
    e.st     = path(pop, pos);
    fin      = (pos > 0) && (pos == lat(op) - 1);
    e.pcwre  = fin && (op != HALT);
    e.irwre  = (e.st == ST_IF);
    e.regwre = (e.st == ST_WBAL) || (e.st == ST_WBLD) || (e.st == ST_ID && op == JAL);
    e.regdst = (e.st == ST_WBAL) ? (is_r(op) ? 2'b10 : 2'b01) :
               (e.st == ST_WBLD) ? 2'b01 : 2'b00;
    e.wrsrc  = (e.st == ST_WBAL) || (e.st == ST_WBLD);
    e.alusrcb = is_i(op) || op == LW || op == SW;
    e.extsel = (op != ORI);
    e.aluop  = (op == SUB || op == BEQ) ? 3'b001 : (op == AND_) ? 3'b010 :
               (op == OR_ || op == ORI) ? 3'b011 : 3'b000;
    e.mrd    = (e.st == ST_MEM) && op == LW;
    e.mwr    = (e.st == ST_MEM) && op == SW;
    e.dbsrc  = (e.st == ST_MEM || e.st == ST_WBLD) && op == LW;
    if (e.st == ST_ID)
      e.pcsrc = (op == J || op == JAL) ? 2'b11 : (op == JR) ? 2'b10 : 2'b00;
    else if (e.st == ST_BR && z)
      e.pcsrc = 2'b01;
    if (rst) begin
      e.pcwre = 0; e.irwre = 0; e.regwre = 0; e.mrd = 0; e.mwr = 0;
    end
    return e;
  endfunction

  function automatic obs_t sample();
    return '{state, PCWre, IRWre, RegWre, RegDst, WrRegDSrc, ALUSrcB, ExtSel,
             ALUOp, mRD, mWR, DBDataSrc, PCSrc};
  endfunction

  // scoreboard: per-cycle compare against the model
  always @(negedge CLK) begin
    obs_t a, e;
    a = sample();
    e = expect_out(opcode, m_op, m_pos, zero, RST);
    n_total++;
    if (a === e) n_pass++;
    else $display("FAIL cycle_cmp t=%0t op=%b: got %h expected %h", $time, opcode, a, e);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // driver tasks
  obs_t snap[16];

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic run(input logic [5:0] op, input logic z, input int ncyc);
    opcode = op;
    zero   = z;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge CLK);
      snap[i] = sample();
      tick();
    end
  endtask

  function automatic logic [5:0] pick_op();
    logic [5:0] tbl [12];
    int k;
    tbl = '{ADD, SUB, OR_, AND_, ADDI, ORI, SW, LW, BEQ, J, JR, JAL};
    k = $urandom_range(0, 15);
    if (k < 12)  return tbl[k];
    if (k < 14)  return 6'($urandom_range(0, 63));
    if (k == 14) return HALT;
    return NOP;
  endfunction

  initial begin
    int halt_cnt;
    logic acc;
    RST = 1'b0;
    opcode = NOP;
    zero = 1'b0;
    #1 RST = 1'b1;
    @(negedge CLK);
    chk("reset_state", {state, PCWre, IRWre, RegWre, mRD, mWR}, 8'h00);
    @(posedge CLK);
    #2 RST = 1'b0;

    // add interrupted by an asynchronous reset in EXE_AL
    opcode = ADD;
    @(negedge CLK); tick();
    @(negedge CLK); tick();
    @(negedge CLK);
    chk("add_in_exe_al", state, ST_AL);
    #3 RST = 1'b1;
    #1 chk("async_reset", {state, PCWre, IRWre, RegWre, mRD, mWR}, 8'h00);
    @(posedge CLK);
    #2 RST = 1'b0;

    run(ADD, 0, 4);
    chk("post_reset_if", {snap[0].st, snap[0].irwre}, 4'b0001);
    chk("add_states", {snap[0].st, snap[1].st, snap[2].st, snap[3].st}, 12'b000_001_110_111);
    chk("add_wb", {snap[3].regwre, snap[3].regdst, snap[3].wrsrc, snap[3].aluop, snap[3].pcwre},
        9'b1_10_1_000_1);
    chk("add_no_early_write", {snap[0].regwre, snap[1].regwre, snap[2].regwre}, 3'b000);
    chk("add_back_to_if", state, ST_IF);

    run(LW, 0, 5);
    chk("lw_states", {snap[0].st, snap[1].st, snap[2].st, snap[3].st, snap[4].st},
        15'b000_001_010_011_100);
    chk("lw_mem", {snap[3].mrd, snap[3].mwr}, 2'b10);
    chk("lw_wb", {snap[4].regwre, snap[4].regdst, snap[4].dbsrc, snap[4].alusrcb, snap[4].extsel},
        6'b1_01_111);

    run(SW, 0, 4);
    chk("sw_mem", {snap[3].st, snap[3].mwr, snap[3].pcwre}, 5'b011_1_1);
    chk("sw_mwr_only_mem", {snap[0].mwr, snap[1].mwr, snap[2].mwr}, 3'b000);
    chk("sw_no_regwre", {snap[0].regwre, snap[1].regwre, snap[2].regwre, snap[3].regwre}, 4'b0000);

    run(ORI, 0, 4);
    chk("ori_wb", {snap[3].extsel, snap[3].aluop, snap[3].regdst}, 6'b0_011_01);

    run(BEQ, 1, 3);
    chk("beq_taken", {snap[2].st, snap[2].pcsrc, snap[2].pcwre}, 6'b101_01_1);
    chk("beq_back_to_if", state, ST_IF);
    run(BEQ, 0, 3);
    chk("beq_not_taken", {snap[2].st, snap[2].pcsrc, snap[2].pcwre}, 6'b101_00_1);

    run(JAL, 0, 2);
    chk("jal_id", {snap[1].st, snap[1].regwre, snap[1].regdst, snap[1].wrsrc, snap[1].pcsrc,
                   snap[1].pcwre}, 10'b001_1_00_0_11_1);
    chk("jal_back_to_if", state, ST_IF);

    run(HALT, 0, 14);
    acc = 1'b0;
    for (int i = 1; i < 14; i++) acc = acc | snap[i].pcwre | snap[i].regwre | snap[i].mwr | snap[i].irwre;
    chk("halt_stuck_id", {snap[13].st, snap[13].pcwre}, 4'b001_0);
    chk("halt_no_enables", acc, 1'b0);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("halt_released", state, ST_IF);

    // randomized phase
    halt_cnt = 0;
    for (int c = 0; c < 3000; c++) begin
      zero = 1'($urandom_range(0, 1));
      halt_cnt = (m_pos == 1 && m_op == HALT) ? halt_cnt + 1 : 0;
      RST = (halt_cnt > 12) || ($urandom_range(0, 99) == 0);
      if (m_pos == 0) opcode = pick_op();
      tick();
    end
    RST = 1'b0;
    @(negedge CLK);
    #1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
